// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Purpose:
//   Converts a parallel word into an asynchronous-serial frame: a start bit (0),
//   the data bits LSB first, and a stop bit (1). The line idles high. The block
//   drives a downstream enable-set D flop. High line levels (idle and stop) are
//   produced by asserting set_out. Low levels and data levels are produced by
//   deasserting set_out and driving d_out.
//
// Parameters:
//   DATA_WIDTH   - payload bits per frame (>= 1)
//   CLKS_PER_BIT - clock cycles each line bit is held (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_in   in   asynchronous active-high reset
//   data_in    in   payload, captured only on an accepted handshake
//   valid_in   in   upstream offers a word
//   ready_out  out  block accepts a word this cycle
//   d_out      out  line data to the flop d input (only meaningful when set_out = 0)
//   set_out    out  forces the line high (flop set/enable)
//   busy_out   out  frame in progress
//   done_out   out  one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  d_out,
    output logic                  set_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  ready_q, ready_d;
    logic                  d_q, d_d;
    logic                  set_q, set_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick_last_s;

    assign tick_last_s = (tick_q == TICK_LAST);

    // State, datapath and output registers; reset returns the line high at once.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            shift_q <= {DATA_WIDTH{1'b0}};
            tick_q  <= {TICK_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            ready_q <= 1'b1;
            d_q     <= 1'b0;
            set_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            ready_q <= ready_d;
            d_q     <= d_d;
            set_q   <= set_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are
    // registered and line up with the state they describe.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in && ready_q) begin
                    shift_d = data_in;
                    tick_d  = {TICK_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_last_s) begin
                    tick_d  = {TICK_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tick_last_s) begin
                    tick_d = {TICK_W{1'b0}};
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (tick_last_s) begin
                    tick_d  = {TICK_W{1'b0}};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        set_d   = (state_d == ST_IDLE) || (state_d == ST_STOP);
        if (state_d == ST_DATA) begin
            d_d = shift_d[0];
        end else begin
            d_d = 1'b0;
        end
    end

    assign ready_out = ready_q;
    assign d_out     = d_q;
    assign set_out   = set_q;
    assign busy_out  = busy_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Self-checking bench for serial_frame_tx. Two instances: dut_a with
// CLKS_PER_BIT = 4 and dut_b with CLKS_PER_BIT = 1. Expected per-cycle output
// vectors {set, d, busy, ready, done} are pushed to a queue when a word is
// sent. They are popped and compared on each falling edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

    logic       clk;
    logic       reset_a, valid_a, ready_a, d_a, set_a, busy_a, done_a;
    logic [7:0] data_a;
    logic       reset_b, valid_b, ready_b, d_b, set_b, busy_b, done_b;
    logic [7:0] data_b;
    logic       flop_q;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];

    localparam logic [4:0] IDLE_V = 5'b1_0_0_1_0;

    serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset_in(reset_a), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .d_out(d_a), .set_out(set_a), .busy_out(busy_a),
        .done_out(done_a)
    );

    serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset_in(reset_b), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .d_out(d_b), .set_out(set_b), .busy_out(busy_b),
        .done_out(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the downstream enable-set flop fed by dut_a.
    always_ff @(posedge clk) flop_q <= set_a ? 1'b1 : d_a;

    function automatic logic [4:0] sample_a();
        return {set_a, d_a, busy_a, ready_a, done_a};
    endfunction

    function automatic logic [4:0] sample_b();
        return {set_b, d_b, busy_b, ready_b, done_b};
    endfunction

    // Expected vectors for one whole frame plus its done cycle.
    task automatic push_frame(input logic [7:0] w, input int cpb);
        for (int c = 0; c < cpb; c++) exp_q.push_back(5'b0_0_1_0_0);
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < cpb; c++) exp_q.push_back({1'b0, w[b], 3'b100});
        for (int c = 0; c < cpb; c++) exp_q.push_back(5'b1_0_1_0_0);
        exp_q.push_back(5'b1_0_0_1_1);
    endtask

    task automatic test_reset();
        logic [4:0] act;
        reset_a = 1'b1; reset_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        #2;
        act = sample_a();
        total++;
        if (act !== IDLE_V) begin
            bad++;
            $display("FAIL reset_a_async got=%b exp=%b", act, IDLE_V);
        end
        act = sample_b();
        total++;
        if (act !== IDLE_V) begin
            bad++;
            $display("FAIL reset_b_async got=%b exp=%b", act, IDLE_V);
        end
        @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            act = sample_a();
            total++;
            if (act !== IDLE_V) begin
                bad++;
                $display("FAIL reset_idle[%0d] got=%b exp=%b", i, act, IDLE_V);
            end
            total++;
            if (flop_q !== 1'b1) begin
                bad++;
                $display("FAIL reset_flop_q[%0d] got=%b exp=1", i, flop_q);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [4:0] act, e;
        int n;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'hA5;
        push_frame(8'hA5, 4);
        exp_q.push_back(IDLE_V);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            act = sample_a();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL frame_a5[%0d] got=%b exp=%b", i, act, e);
            end
            valid_a = 1'b0; data_a = 8'h00;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] act, e;
        int n;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'h3C;
        push_frame(8'h3C, 4);
        push_frame(8'h3C, 4);
        exp_q.push_back(IDLE_V);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            act = sample_a();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL b2b_3c[%0d] got=%b exp=%b", i, act, e);
            end
            if (i == 0) data_a = 8'hFF;
            if (i == 38) data_a = 8'h3C;
            if (i == 41) begin
                valid_a = 1'b0; data_a = 8'h00;
            end
        end
    endtask

    task automatic test_one_clk_per_bit();
        logic [4:0] act, e;
        int n;
        @(negedge clk);
        valid_b = 1'b1; data_b = 8'hFF;
        push_frame(8'hFF, 1);
        exp_q.push_back(IDLE_V);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            act = sample_b();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cpb1_ff[%0d] got=%b exp=%b", i, act, e);
            end
            valid_b = 1'b0; data_b = 8'h00;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0] act, e;
        int n;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'h0F;
        push_frame(8'h0F, 4);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            act = sample_a();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL pre_reset_0f[%0d] got=%b exp=%b", i, act, e);
            end
            valid_a = 1'b0; data_a = 8'h00;
        end
        exp_q.delete();
        reset_a = 1'b1;
        #1;
        act = sample_a();
        total++;
        if (act !== IDLE_V) begin
            bad++;
            $display("FAIL mid_reset_line got=%b exp=%b", act, IDLE_V);
        end
        @(negedge clk);
        reset_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            act = sample_a();
            total++;
            if (act !== IDLE_V) begin
                bad++;
                $display("FAIL post_reset_idle[%0d] got=%b exp=%b", i, act, IDLE_V);
            end
        end
        valid_a = 1'b1; data_a = 8'h81;
        push_frame(8'h81, 4);
        exp_q.push_back(IDLE_V);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            act = sample_a();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL frame_81[%0d] got=%b exp=%b", i, act, e);
            end
            valid_a = 1'b0; data_a = 8'h00;
        end
    endtask

    task automatic test_valid_during_stop();
        logic [4:0] act, e;
        int n;
        int dones;
        dones = 0;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'h55;
        push_frame(8'h55, 4);
        for (int i = 0; i < 3; i++) exp_q.push_back(IDLE_V);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            act = sample_a();
            if (done_a === 1'b1) dones++;
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL stop_valid_55[%0d] got=%b exp=%b", i, act, e);
            end
            if (i == 37) valid_a = 1'b1;
            else valid_a = 1'b0;
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL stop_valid_done_count got=%0d exp=1", dones);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_one_clk_per_bit();
        test_reset_mid_frame();
        test_valid_during_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
